// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file, writeback stage and decode.
package cpu_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int CNTW = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: storage mux with r0 forced to zero and,
// when REGFILE_BYPASS_EN is defined, write-through forwarding from the writeback inputs.
module reg_file_rdport #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] regs [NREG],
`ifdef REGFILE_BYPASS_EN
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
`endif
    output logic [DW-1:0] data
);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        data = '0;
        if (addr != '0) begin
            data = regs[addr];
`ifdef REGFILE_BYPASS_EN
            // wr_en already excludes r0, so forwarding never overrides the hardwired zero.
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file with two combinational read ports, write counter and last-write record.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int NREG = cpu_pkg::NREG,
    parameter int AW   = cpu_pkg::AW,
    parameter int DW   = cpu_pkg::DW,
    parameter int CNTW = cpu_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   rw,
    input  logic [DW-1:0]   din,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic [DW-1:0]   busa,
    output logic [DW-1:0]   busb,
    output logic [CNTW-1:0] wr_cnt,
    output logic [AW-1:0]   last_rw,
    output logic [DW-1:0]   last_din
);

    import cpu_pkg::*;

    logic [DW-1:0] regs [NREG];
    logic          commit;

    // An X on we makes commit X, which the if below treats as false: storage stays clean.
    assign commit = we && (rw != AW'(REG_ZERO));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the storage array is reset here because reads after reset must return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wr_cnt   <= '0;
            last_rw  <= '0;
            last_din <= '0;
        end else if (commit) begin
            regs[rw] <= din;
            wr_cnt   <= wr_cnt + CNTW'(1);
            last_rw  <= rw;
            last_din <= din;
        end
    end

    reg_file_rdport #(.NREG(NREG), .AW(AW), .DW(DW)) u_rdport_a (
        .addr    (ra),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (commit),
        .wr_addr (rw),
        .wr_data (din),
`endif
        .data    (busa)
    );

    reg_file_rdport #(.NREG(NREG), .AW(AW), .DW(DW)) u_rdport_b (
        .addr    (rb),
        .regs    (regs),
`ifdef REGFILE_BYPASS_EN
        .wr_en   (commit),
        .wr_addr (rw),
        .wr_data (din),
`endif
        .data    (busb)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  rw;
    logic [31:0] din;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] busa;
    logic [31:0] busb;
    logic [31:0] wr_cnt;
    logic [4:0]  last_rw;
    logic [31:0] last_din;

    // Narrow-counter instance used only to exercise counter wrap-around.
    logic        w_we;
    logic [4:0]  w_rw;
    logic [31:0] w_din;
    logic [4:0]  w_ra;
    logic [31:0] w_busa;
    logic [31:0] w_busb;
    logic [3:0]  w_cnt;
    logic [4:0]  w_last_rw;
    logic [31:0] w_last_din;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model.
    logic [31:0] mem [32];
    logic [31:0] m_cnt;
    logic [4:0]  m_lrw;
    logic [31:0] m_ldin;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .ra(ra), .rb(rb),
        .busa(busa), .busb(busb), .wr_cnt(wr_cnt), .last_rw(last_rw), .last_din(last_din)
    );

    reg_file #(.CNTW(4)) dut_w (
        .clk(clk), .rst(rst), .we(w_we), .rw(w_rw), .din(w_din), .ra(w_ra), .rb(w_ra),
        .busa(w_busa), .busb(w_busb), .wr_cnt(w_cnt), .last_rw(w_last_rw), .last_din(w_last_din)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we === 1'b1 && rw == a) return din;
`endif
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        m_cnt  = 32'h0;
        m_lrw  = 5'd0;
        m_ldin = 32'h0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".busa"},     busa,            expect_rd(ra));
        check({tag, ".busb"},     busb,            expect_rd(rb));
        check({tag, ".wr_cnt"},   wr_cnt,          m_cnt);
        check({tag, ".last_rw"},  {27'h0, last_rw}, {27'h0, m_lrw});
        check({tag, ".last_din"}, last_din,        m_ldin);
    endtask

    // Inputs are driven just after a negedge; check reads before the edge, then full state after it.
    task automatic cycle(input string tag);
        #1;
        check({tag, ".pre_a"}, busa, expect_rd(ra));
        check({tag, ".pre_b"}, busb, expect_rd(rb));
        @(posedge clk);
        if (we === 1'b1 && rw != 5'd0) begin
            mem[rw] = din;
            m_cnt   = m_cnt + 32'd1;
            m_lrw   = rw;
            m_ldin  = din;
        end
        #1;
        check_state({tag, ".post"});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; rw = '0; din = '0; ra = '0; rb = '0;
        w_we = 1'b0; w_rw = '0; w_din = '0; w_ra = '0;
        model_clear();
        @(negedge clk);
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic write/read.
        we = 1'b1; rw = 5'd5; din = 32'hDEADBEEF; ra = 5'd5; rb = 5'd0;
        cycle("basic");
        check("basic.const_a", busa, 32'hDEADBEEF);
        check("basic.const_cnt", wr_cnt, 32'd1);

        // r0 write is dropped.
        we = 1'b1; rw = 5'd0; din = 32'h12345678; ra = 5'd0; rb = 5'd5;
        cycle("r0");
        check("r0.const_a", busa, 32'h0);

        // Same-cycle read/write of one address.
        we = 1'b1; rw = 5'd7; din = 32'h1; ra = 5'd3; rb = 5'd5;
        cycle("same_setup");
        we = 1'b1; rw = 5'd7; din = 32'h2; ra = 5'd7; rb = 5'd7;
        cycle("same_rw");
        check("same_rw.const_b", busb, 32'h2);

        // Asynchronous reset mid-cycle with prior contents.
        we = 1'b0; ra = 5'd5; rb = 5'd7;
        #2 rst = 1'b1;
        model_clear();
        #1;
        check("async_rst.busa", busa, 32'h0);
        check("async_rst.busb", busb, 32'h0);
        check("async_rst.wr_cnt", wr_cnt, 32'h0);
        check("async_rst.last_din", last_din, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            check("async_rst.sweep_a", busa, 32'h0);
            check("async_rst.sweep_b", busb, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back writes to r1..r31.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rw = 5'(i); din = i * 32'h01010101; ra = 5'(i); rb = 5'(i - 1);
            cycle("b2b");
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            check("sweep.busa", busa, (i == 0) ? 32'h0 : i * 32'h01010101);
            check("sweep.busb", busb, (i == 31) ? 32'h0 : (31 - i) * 32'h01010101);
        end
        check("sweep.wr_cnt", wr_cnt, 32'd31);
        check("sweep.last_rw", {27'h0, last_rw}, 32'd31);
        @(negedge clk);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            rw  = 5'($urandom_range(0, 31));
            din = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            cycle("rand");
        end

`ifdef TB_XPROP
        // X on we must not corrupt storage.
        we = 1'bx; rw = 5'd9; din = 32'hBADBAD00; ra = 5'd9; rb = 5'd9;
        #1;
        check("xprop.pre", busa, mem[9]);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("xprop.post", busa, mem[9]);
        check("xprop.cnt", wr_cnt, m_cnt);
        @(negedge clk);
`endif

        // Write pending at the same edge as reset assertion is lost.
        we = 1'b1; rw = 5'd9; din = 32'hAAAA5555; ra = 5'd9; rb = 5'd0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        check("rst_pending.busa", busa, 32'h0);
        check("rst_pending.wr_cnt", wr_cnt, 32'h0);
        @(negedge clk);

        // Counter wrap on the 4-bit instance.
        w_ra = 5'd1;
        for (int i = 1; i <= 16; i++) begin
            w_we = 1'b1; w_rw = 5'd1; w_din = 32'(i) * 32'h11;
            @(posedge clk);
            #1;
            if (i == 15) check("wrap.cnt15", {28'h0, w_cnt}, 32'd15);
            @(negedge clk);
        end
        w_we = 1'b0;
        #1;
        check("wrap.cnt0", {28'h0, w_cnt}, 32'd0);
        check("wrap.busa", w_busa, 32'd16 * 32'h11);
        check("wrap.busb", w_busb, 32'd16 * 32'h11);
        check("wrap.last_rw", {27'h0, w_last_rw}, 32'd1);
        check("wrap.last_din", w_last_din, 32'd16 * 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
